// File: rtl/memory_model_burst_if.sv
// Request/response bus of the burst memory model: request and write data in,
// read data and per-beat status out.
interface memory_model_burst_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADR_WIDTH  = 16
);
    logic [ADR_WIDTH-1:0]  address;
    logic [DATA_WIDTH-1:0] datain;
    logic [DATA_WIDTH-1:0] dataout;
    logic                  rd;
    logic                  wr;
    logic                  ready;
    logic                  done;
    logic                  busy;

    modport master (
        output address, datain, rd, wr,
        input  dataout, ready, done, busy
    );

    modport slave (
        input  address, datain, rd, wr,
        output dataout, ready, done, busy
    );
endinterface

// File: rtl/memory_model_burst.sv
// Burst memory model: fixed initial latency, then one aligned cache line of
// 2^BURST_WIDTH words, one word per cycle.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for rd/wr; address and op latched on request
// WAIT_MEM | initial access latency, 2^DELAY_FACTOR cycles
// BURST    | one beat per cycle, ready=1, done on the last beat
module memory_model_burst #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADR_WIDTH    = 16,
    parameter int DELAY_FACTOR = 2,
    parameter int BURST_WIDTH  = 2,
    parameter int MEM_SIZE     = 1 << ADR_WIDTH
) (
    input logic                clk,
    input logic                rst,
    memory_model_burst_if.slave bus
);
    localparam int MEM_AW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam logic [ADR_WIDTH-1:0] LINE_MASK = ~ADR_WIDTH'((1 << BURST_WIDTH) - 1);

    typedef enum logic [1:0] {IDLE, WAIT_MEM, BURST} state_t;

    state_t                  state;
    logic [DELAY_FACTOR-1:0] lat_cnt;
    logic [BURST_WIDTH-1:0]  beat_cnt;
    logic [ADR_WIDTH-1:0]    base;
    logic                    op_rd;
    logic                    ready_q;
    logic                    done_q;
    logic                    busy_q;
    logic [DATA_WIDTH-1:0]   dataout_q;

    logic [DATA_WIDTH-1:0]   mem [0:MEM_SIZE-1];

    logic [BURST_WIDTH-1:0]  beat_nxt;
    logic [ADR_WIDTH-1:0]    beat_addr;
    logic [ADR_WIDTH-1:0]    beat_addr_nxt;

    function automatic logic [MEM_AW-1:0] mem_idx(input logic [ADR_WIDTH-1:0] a);
        return MEM_AW'(32'(a) % 32'(MEM_SIZE));
    endfunction

    // base is line aligned, so adding the beat count never carries out of the line
    assign beat_nxt      = beat_cnt + 1'b1;
    assign beat_addr     = base + ADR_WIDTH'(beat_cnt);
    assign beat_addr_nxt = base + ADR_WIDTH'(beat_nxt);

    // Outputs are registered from the next-state decision so they are clean
    // Moore outputs of the state the FSM is entering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            beat_cnt  <= '0;
            base      <= '0;
            op_rd     <= 1'b0;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            dataout_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ready_q   <= 1'b0;
                    done_q    <= 1'b0;
                    dataout_q <= '0;
                    if (bus.rd || bus.wr) begin
                        base     <= bus.address & LINE_MASK;
                        op_rd    <= bus.rd;
                        lat_cnt  <= '0;
                        beat_cnt <= '0;
                        busy_q   <= 1'b1;
                        state    <= WAIT_MEM;
                    end else begin
                        busy_q   <= 1'b0;
                    end
                end
                WAIT_MEM: begin
                    lat_cnt <= lat_cnt + 1'b1;
                    busy_q  <= 1'b1;
                    if (&lat_cnt) begin
                        state     <= BURST;
                        ready_q   <= 1'b1;
                        done_q    <= &beat_cnt;
                        dataout_q <= op_rd ? mem[mem_idx(base)] : '0;
                    end
                end
                BURST: begin
                    beat_cnt <= beat_nxt;
                    if (&beat_cnt) begin
                        state     <= IDLE;
                        ready_q   <= 1'b0;
                        done_q    <= 1'b0;
                        busy_q    <= 1'b0;
                        dataout_q <= '0;
                    end else begin
                        ready_q   <= 1'b1;
                        done_q    <= &beat_nxt;
                        busy_q    <= 1'b1;
                        dataout_q <= op_rd ? mem[mem_idx(beat_addr_nxt)] : '0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    ready_q   <= 1'b0;
                    done_q    <= 1'b0;
                    busy_q    <= 1'b0;
                    dataout_q <= '0;
                end
            endcase
        end
    end

    // Storage has no reset; an async reset forces IDLE, which stops writes at once.
    always_ff @(posedge clk) begin
        if (state == BURST && !op_rd)
            mem[mem_idx(beat_addr)] <= bus.datain;
    end

    assign bus.ready   = ready_q;
    assign bus.done    = done_q;
    assign bus.busy    = busy_q;
    assign bus.dataout = dataout_q;
endmodule

// File: tb/tb_memory_model_burst.sv
// Directed bench for memory_model_burst: reset, read, write/read-back,
// top-of-memory collision, mid-burst reset and back-to-back bursts.
module tb_memory_model_burst;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    memory_model_burst_if #(.DATA_WIDTH(16), .ADR_WIDTH(16)) bus ();

    memory_model_burst dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, " idle busy"},    32'(bus.busy),    32'd0);
        check_eq({tag, " idle ready"},   32'(bus.ready),   32'd0);
        check_eq({tag, " idle done"},    32'(bus.done),    32'd0);
        check_eq({tag, " idle dataout"}, 32'(bus.dataout), 32'd0);
    endtask

    // Present a request for one cycle; returns at the negedge after the sampling edge.
    task automatic issue(input logic r, input logic w, input logic [15:0] a);
        bus.rd      = r;
        bus.wr      = w;
        bus.address = a;
        @(negedge clk);
        bus.rd      = 1'b0;
        bus.wr      = 1'b0;
        bus.address = 16'h5555;
    endtask

    // Entered at the first WAIT_MEM negedge. Checks 4 wait cycles and 4 beats,
    // driving write data per beat. abort_beat >= 0 asserts rst in that beat.
    task automatic burst_body(input string tag, input logic [63:0] wwords,
                              input logic [63:0] rwords, input bit exp_rd,
                              input int abort_beat);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("%s wait%0d busy", tag, i),    32'(bus.busy),    32'd1);
            check_eq($sformatf("%s wait%0d ready", tag, i),   32'(bus.ready),   32'd0);
            check_eq($sformatf("%s wait%0d dataout", tag, i), 32'(bus.dataout), 32'd0);
            @(negedge clk);
        end
        for (int k = 0; k < 4; k++) begin
            if (k == abort_beat) begin
                rst = 1'b0;
                #1;
                check_idle({tag, " async reset"});
                @(negedge clk);
                check_eq({tag, " held in reset busy"}, 32'(bus.busy), 32'd0);
                return;
            end
            bus.datain = wwords[16*k +: 16];
            check_eq($sformatf("%s beat%0d ready", tag, k), 32'(bus.ready), 32'd1);
            check_eq($sformatf("%s beat%0d busy", tag, k),  32'(bus.busy),  32'd1);
            check_eq($sformatf("%s beat%0d done", tag, k),  32'(bus.done),  (k == 3) ? 32'd1 : 32'd0);
            check_eq($sformatf("%s beat%0d dataout", tag, k), 32'(bus.dataout),
                     exp_rd ? 32'(rwords[16*k +: 16]) : 32'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b0;
        bus.rd      = 1'b0;
        bus.wr      = 1'b0;
        bus.address = 16'h0000;
        bus.datain  = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            dut.mem[16'h0010 + i] = 16'hA000 + 16'(i);
            dut.mem[16'hFFFC + i] = 16'hB000 + 16'(i);
            dut.mem[16'h0080 + i] = 16'hEEEE;
        end
        dut.mem[16'h0000] = 16'h5A5A;

        #1;
        check_idle("reset");

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Read burst from a mid-line address: line 0x0010..0x0013
        issue(1'b1, 1'b0, 16'h0012);
        burst_body("rd12", 64'h0, 64'hA003_A002_A001_A000, 1'b1, -1);
        check_idle("rd12 end");

        // Write line 0x0040, read it back from 0x0043
        issue(1'b0, 1'b1, 16'h0040);
        burst_body("wr40", 64'h4444_3333_2222_1111, 64'h0, 1'b0, -1);
        check_idle("wr40 end");
        issue(1'b1, 1'b0, 16'h0043);
        burst_body("rd43", 64'h0, 64'h4444_3333_2222_1111, 1'b1, -1);
        check_idle("rd43 end");

        // rd and wr together at the top of memory: a read, nothing written
        issue(1'b1, 1'b1, 16'hFFFE);
        burst_body("top", 64'hDEAD_DEAD_DEAD_DEAD, 64'hB003_B002_B001_B000, 1'b1, -1);
        check_idle("top end");
        for (int i = 0; i < 4; i++)
            check_eq($sformatf("top mem%0d kept", i), 32'(dut.mem[16'hFFFC + i]), 32'hB000 + i);
        check_eq("top no wrap mem0", 32'(dut.mem[16'h0000]), 32'h5A5A);

        // Write burst to 0x0080 aborted by reset after beat 1
        issue(1'b0, 1'b1, 16'h0080);
        burst_body("abort", 64'h0D0D_0C0C_0B0B_0A0A, 64'h0, 1'b0, 2);
        check_eq("abort mem80", 32'(dut.mem[16'h0080]), 32'h0A0A);
        check_eq("abort mem81", 32'(dut.mem[16'h0081]), 32'h0B0B);
        check_eq("abort mem82", 32'(dut.mem[16'h0082]), 32'hEEEE);
        check_eq("abort mem83", 32'(dut.mem[16'h0083]), 32'hEEEE);

        // Release reset with rd already high and keep it high: back-to-back reads
        rst         = 1'b1;
        bus.rd      = 1'b1;
        bus.address = 16'h0011;
        @(negedge clk);
        burst_body("b2b0", 64'h0, 64'hA003_A002_A001_A000, 1'b1, -1);
        check_eq("b2b gap0 busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        burst_body("b2b1", 64'h0, 64'hA003_A002_A001_A000, 1'b1, -1);
        check_eq("b2b gap1 busy", 32'(bus.busy), 32'd0);
        bus.rd = 1'b0;
        @(negedge clk);
        check_idle("b2b end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
